// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg: shared UART constants (APB access size codes, FIFO defaults)
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;

    localparam int UART_FIFO_DATA_W = 32;
    localparam int UART_FIFO_DEPTH  = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/apb_uart_rx_fifo_if.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_uart_rx_fifo_if: push/pop, control and status bundle of the RX FIFO
// Rev 1.0
// ------------------------------------------------------------------
interface apb_uart_rx_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              psel;
    logic              rd_en;
    logic [1:0]        size;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, psel, rd_en, size, flush, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, psel, rd_en, size, flush, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface : apb_uart_rx_fifo_if
`default_nettype wire

// File: rtl/fifo_mem_sp2.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_mem_sp2: register-array storage, synchronous write, asynchronous read
// Rev 1.0
// ------------------------------------------------------------------
module fifo_mem_sp2 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [DATA_W-1:0]        wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : fifo_mem_sp2
`default_nettype wire

// File: rtl/apb_uart_rx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_uart_rx_fifo: parametrised UART receive FIFO with size-masked APB pop path
// Rev 1.0
// ------------------------------------------------------------------
module apb_uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_FIFO_DATA_W,
    parameter int DEPTH    = UART_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  wire logic          PCLK,
    input  wire logic          PRESETn,
    apb_uart_rx_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_af_level = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ae_level = AE_LEVEL[ADDR_W:0];

    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_mask_data;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                     (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

    assign w_push = bus.wr_en & ~w_full & ~bus.flush;
    assign w_pop  = bus.psel & bus.rd_en & ~w_empty & ~bus.flush;

    fifo_mem_sp2 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (w_push),
        .waddr (r_wptr[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .raddr (r_rptr[ADDR_W-1:0]),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        w_mask_data = w_mem_rdata;
        case (bus.size)
            SIZE_BYTE: w_mask_data = {{(DATA_W-8){1'b0}},  w_mem_rdata[7:0]};
            SIZE_HALF: w_mask_data = {{(DATA_W-16){1'b0}}, w_mem_rdata[15:0]};
            default:   w_mask_data = w_mem_rdata;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (bus.flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            if (w_pop) r_rd_data <= w_mask_data;

            // Set has priority over clear so no error event is lost.
            if (bus.wr_en & w_full)                 r_overflow <= 1'b1;
            else if (bus.clr_err)                   r_overflow <= 1'b0;
            if (bus.psel & bus.rd_en & w_empty)     r_underflow <= 1'b1;
            else if (bus.clr_err)                   r_underflow <= 1'b0;
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_count >= c_af_level);
    assign bus.almost_empty = (w_count <= c_ae_level);
    assign bus.count        = w_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule : apb_uart_rx_fifo
`default_nettype wire
